// File: rtl/sim_test_monitor.sv
// sim_test_monitor: snoops bus stores into an MMIO region and latches a pass/fail/timeout verdict.
// Console FIFO is built only when SIM_TEST_MONITOR_CONSOLE_EN is defined.
module sim_test_monitor #(
    parameter int          N_CH           = 1,
    parameter logic [3:0]  REGION_ID      = 4'h1,
    parameter logic [31:0] PASS_CODE      = 32'h777,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'd1_000_000,
    parameter int          CON_DEPTH      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [32*N_CH-1:0] dbus_cmd_addr_i,
    input  logic [N_CH-1:0]   dbus_cmd_we_i,
    input  logic [32*N_CH-1:0] dbus_wdata_data_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [31:0]       fail_code_o,
    output logic [2:0]        fail_ch_o,
    output logic [63:0]       cycle_o,
    output logic              con_valid_o,
    output logic [7:0]        con_data_o,
    input  logic              con_ready_i,
    output logic              con_overflow_o
);
    typedef enum logic {RUN, DONE} state_e;
    state_e state_q;
    logic [N_CH-1:0] reported_q, rep_d, st_ok, st_bad, con_hit;
    logic [31:0] fail_code_q, fail_data;
    logic [2:0] fail_ch_q, fail_idx;
    logic [63:0] cycle_q;
    logic pass_q, timeout_q, to_hit, unused_bits;
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic hit;
        assign hit = dbus_cmd_we_i[g] && dbus_cmd_addr_i[32*g+28 +: 4] == REGION_ID;
        assign st_ok[g] = hit && dbus_cmd_addr_i[32*g+2 +: 2] == 2'd0 && dbus_wdata_data_i[32*g +: 32] == PASS_CODE;
        assign st_bad[g] = hit && dbus_cmd_addr_i[32*g+2 +: 2] == 2'd0 && dbus_wdata_data_i[32*g +: 32] != PASS_CODE;
        assign con_hit[g] = hit && dbus_cmd_addr_i[32*g+2 +: 2] == 2'd1;
    end
    // Descending scan so the lowest failing channel is the one left standing.
    always_comb begin
        fail_idx = '0;
        fail_data = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (st_bad[k]) begin
                fail_idx = k[2:0];
                fail_data = dbus_wdata_data_i[32*k +: 32];
            end
    end
    assign rep_d = reported_q | st_ok;
    assign to_hit = TIMEOUT_CYCLES != 64'd0 && cycle_q == TIMEOUT_CYCLES - 64'd1;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            reported_q <= '0;
            cycle_q <= '0;
            pass_q <= 1'b0;
            timeout_q <= 1'b0;
            fail_code_q <= '0;
            fail_ch_q <= '0;
        end else if (state_q == RUN) begin
            cycle_q <= cycle_q + 64'd1;
            reported_q <= rep_d;
            if (|st_bad) begin
                state_q <= DONE;
                fail_code_q <= fail_data;
                fail_ch_q <= fail_idx;
            end else if (&rep_d) begin
                state_q <= DONE;
                pass_q <= 1'b1;
            end else if (to_hit) begin
                state_q <= DONE;
                timeout_q <= 1'b1;
            end
        end
    end
    assign done_o = state_q == DONE;
    assign pass_o = pass_q;
    assign timeout_o = timeout_q;
    assign fail_code_o = fail_code_q;
    assign fail_ch_o = fail_ch_q;
    assign cycle_o = cycle_q;
`ifdef SIM_TEST_MONITOR_CONSOLE_EN
    localparam int AW = $clog2(CON_DEPTH);
    logic [7:0] mem_q [CON_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic [7:0] push_data;
    logic ovf_q, full, pop, push;
    always_comb begin
        push_data = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (con_hit[k]) push_data = dbus_wdata_data_i[32*k +: 8];
    end
    assign full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    assign con_valid_o = wr_q != rd_q;
    assign pop = con_valid_o && con_ready_i;
    assign push = |con_hit && (!full || pop);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if ($countones(con_hit) > 1 || (|con_hit && !push)) ovf_q <= 1'b1;
        end
    end
    always_ff @(posedge clk_i)
        if (push) mem_q[wr_q[AW-1:0]] <= push_data;
    assign con_data_o = con_valid_o ? mem_q[rd_q[AW-1:0]] : 8'h00;
    assign con_overflow_o = ovf_q;
    assign unused_bits = ^dbus_cmd_addr_i;
`else
    assign con_valid_o = 1'b0;
    assign con_data_o = 8'h00;
    assign con_overflow_o = 1'b0;
    assign unused_bits = ^{dbus_cmd_addr_i, con_ready_i, con_hit};
`endif
endmodule

// File: tb/tb_sim_test_monitor.sv
// tb_sim_test_monitor: directed checks on a single-channel and a dual-channel monitor.
module tb_sim_test_monitor;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [31:0] a_addr = '0, a_data = '0, a_code;
    logic a_we = 1'b0, a_rdy = 1'b0;
    logic [63:0] b_addr = '0, b_data = '0;
    logic [1:0] b_we = '0;
    logic b_rdy = 1'b0;
    logic a_done, a_pass, a_to, a_val, a_ovf, b_done, b_pass, b_to, b_val, b_ovf;
    logic [2:0] a_ch, b_ch;
    logic [31:0] b_code;
    logic [63:0] a_cyc, b_cyc;
    logic [7:0] a_cd, b_cd;
    int total = 0, bad = 0, cyc = 0;
    logic [7:0] msg [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    logic [7:0] fill [4] = '{8'h50, 8'h51, 8'h52, 8'h53};
    logic [7:0] drain [4] = '{8'h51, 8'h52, 8'h53, 8'h58};

    sim_test_monitor #(.N_CH(1), .TIMEOUT_CYCLES(64'd0), .CON_DEPTH(4)) u_a (
        .clk_i(clk), .rst_i(rst), .dbus_cmd_addr_i(a_addr), .dbus_cmd_we_i(a_we),
        .dbus_wdata_data_i(a_data), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_to),
        .fail_code_o(a_code), .fail_ch_o(a_ch), .cycle_o(a_cyc), .con_valid_o(a_val),
        .con_data_o(a_cd), .con_ready_i(a_rdy), .con_overflow_o(a_ovf));
    sim_test_monitor #(.N_CH(2), .TIMEOUT_CYCLES(64'd100), .CON_DEPTH(4)) u_b (
        .clk_i(clk), .rst_i(rst), .dbus_cmd_addr_i(b_addr), .dbus_cmd_we_i(b_we),
        .dbus_wdata_data_i(b_data), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_to),
        .fail_code_o(b_code), .fail_ch_o(b_ch), .cycle_o(b_cyc), .con_valid_o(b_val),
        .con_data_o(b_cd), .con_ready_i(b_rdy), .con_overflow_o(b_ovf));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step();
        cyc = 0;
        rst = 1'b0;
    endtask
    task automatic goto(input int n);
        while (cyc < n) step();
    endtask
    task automatic a_wr(input logic [31:0] addr, input logic [31:0] data);
        a_we = 1'b1;
        a_addr = addr;
        a_data = data;
        step();
        a_we = 1'b0;
    endtask
    task automatic b_wr(input logic [1:0] we, input logic [63:0] addr, input logic [63:0] data);
        b_we = we;
        b_addr = addr;
        b_data = data;
        step();
        b_we = '0;
    endtask

    initial begin
        do_reset();
        check("rst_done", {a_done, b_done}, 0);
        check("rst_flags", {a_pass, a_to, b_pass, b_to}, 0);
        check("rst_fail", {b_code, 29'd0, b_ch}, 0);
        check("rst_cycle", b_cyc, 0);
        check("rst_con", {a_val, a_cd, a_ovf}, 0);
        goto(5);
        b_wr(2'b10, 64'h1000_0000_1000_0000, 64'h0000_0777_0000_0000);
        check("b_partial", b_done, 0);
        b_wr(2'b11, 64'h1000_0000_1000_0000, 64'h0000_BEEF_0000_DEAD);
        check("b_fail_done", {b_done, b_pass, b_to}, 3'b100);
        check("b_fail_ch", b_ch, 0);
        check("b_fail_code", b_code, 64'hDEAD);
        check("b_fail_cyc", b_cyc, 7);
        a_wr(32'h1000_0008, 32'hBAD);
        a_wr(32'h2000_0000, 32'hBAD);
        a_wr(32'h1000_000C, 32'hBAD);
        check("a_ignored", a_done, 0);
        goto(50);
        a_wr(32'h1000_0000, 32'h777);
        check("a_pass", {a_done, a_pass, a_to}, 3'b110);
        check("a_pass_cyc", a_cyc, 51);
        goto(55);
        check("a_frozen", a_cyc, 51);
        check("b_frozen", {b_cyc, b_code}, {64'd7, 32'hDEAD});
        do_reset();
        check("b_rst_done", {b_done, b_pass, b_to}, 0);
        check("b_rst_fail", {b_code, 29'd0, b_ch}, 0);
        check("b_rst_cyc", b_cyc, 0);
        b_wr(2'b01, 64'h1000_0000, 64'h777);
        b_wr(2'b10, 64'h1000_0000_0000_0000, 64'h0000_0777_0000_0000);
        check("b_repass", {b_done, b_pass, b_to}, 3'b110);
        do_reset();
        goto(99);
        check("b_pre_to", b_done, 0);
        step();
        check("b_to", {b_done, b_pass, b_to}, 3'b101);
        check("b_to_cyc", b_cyc, 100);
        b_wr(2'b11, 64'h1000_0000_1000_0000, 64'h0000_0777_0000_0777);
        step();
        check("b_to_hold", {b_pass, b_to, b_cyc}, {2'b01, 64'd100});
        check("a_no_to", {a_done, a_cyc}, {1'b0, 64'd102});
        do_reset();
        b_wr(2'b01, 64'h1000_0000, 64'h777);
        goto(99);
        b_wr(2'b10, 64'h1000_0000_0000_0000, 64'h0000_0777_0000_0000);
        check("b_pass_at_to", {b_done, b_pass, b_to}, 3'b110);
        do_reset();
        a_rdy = 1'b0;
        foreach (msg[i]) a_wr(32'h1000_0004, {24'h0, msg[i]});
`ifdef SIM_TEST_MONITOR_CONSOLE_EN
        check("con_ovf", {a_ovf, a_val, a_cd}, {2'b11, 8'h41});
        a_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("con_drain", {a_val, a_cd}, {1'b1, msg[i]});
            step();
        end
        check("con_empty", a_val, 0);
`else
        check("con_off", {a_ovf, a_val, a_cd}, 0);
`endif
        a_rdy = 1'b0;
        do_reset();
        check("con_rst", {a_ovf, a_val}, 0);
        foreach (fill[i]) a_wr(32'h1000_0004, {24'h0, fill[i]});
        a_rdy = 1'b1;
        a_wr(32'h1000_0004, 32'h58);
        a_rdy = 1'b0;
        b_wr(2'b11, 64'h1000_0004_1000_0004, 64'h0000_006E_0000_006D);
`ifdef SIM_TEST_MONITOR_CONSOLE_EN
        check("con_x_ovf", a_ovf, 0);
        a_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("con_x_drain", {a_val, a_cd}, {1'b1, drain[i]});
            step();
        end
        check("con_x_empty", a_val, 0);
        check("con_multi", {b_ovf, b_val, b_cd}, {2'b11, 8'h6D});
        b_rdy = 1'b1;
        step();
        check("con_multi_one", b_val, 0);
`else
        check("con_off_b", {b_ovf, b_val, b_cd, a_val}, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sim_test_monitor.md
# sim_test_monitor

Synthesizable multi-hart test-completion monitor for simulation and FPGA self-check builds. It snoops one or more CPU data-bus write channels for stores into a reserved MMIO region. Pass/fail reports from each channel are collected, console bytes are buffered for draining, and a cycle budget is enforced. A single latched verdict (pass, fail with code, or timeout) is presented to the testbench or board logic.

## Interface
- `N_CH`, 1, number of snooped bus channels (harts), 1..8
- `REGION_ID`, 4'h1, value of `addr[31:28]` that selects the monitor region
- `PASS_CODE`, 32'h777, status word meaning "this channel passed"
- `TIMEOUT_CYCLES`, 1_000_000, cycle budget; 0 disables the timeout
- `CON_DEPTH`, 16, console FIFO depth in bytes; power of two, 2..256
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `dbus_cmd_addr_i`  in  32*N_CH  per-channel store address; channel k occupies bits `[32k+31:32k]`
- `dbus_cmd_we_i`  in  N_CH  per-channel write strobe; one store per asserted cycle
- `dbus_wdata_data_i`  in  32*N_CH  per-channel store data
- `done_o`  out  1  verdict latched
- `pass_o`  out  1  all channels reported `PASS_CODE`
- `timeout_o`  out  1  cycle budget exhausted before a verdict
- `fail_code_o`  out  32  data of the failing status write
- `fail_ch_o`  out  3  index of the failing channel
- `cycle_o`  out  64  cycles since reset; freezes when `done_o` rises
- `con_valid_o`  out  1  console byte available
- `con_data_o`  out  8  console byte at the FIFO head
- `con_ready_i`  in  1  consumer accepts the byte
- `con_overflow_o`  out  1  sticky: a console byte was dropped

## Operation
- Hit decode for channel k: `we[k]` is set and `addr[31:28]` equals `REGION_ID`. Offset `addr[3:2]`:
  - 0 = STATUS
  - 1 = CONSOLE
  - 2 and 3 are ignored.
- State machine has two states, RUN and DONE. Reset enters RUN.
- In RUN, a STATUS write with data equal to `PASS_CODE` sets `reported[k]`. Repeat writes are harmless.
- In RUN, a STATUS write with any other data causes a FAIL:
  - go to DONE;
  - `fail_code_o` takes the write data;
  - `fail_ch_o` takes k.
- Simultaneous FAIL writes from several channels: the lowest channel index wins.
- When all N_CH bits of `reported` are set, go to DONE with `pass_o` set to 1.
- Timeout: when `cycle_o` equals `TIMEOUT_CYCLES-1` while in RUN, go to DONE with `timeout_o` set to 1.
- Same-cycle priority is FAIL, then all-reported, then timeout. A pass-completing write in the timeout cycle still passes.
- DONE is terminal until `rst_i`. All STATUS writes are ignored and the outputs hold.
- A CONSOLE write pushes `data[7:0]` into the FIFO. Only one push is accepted per cycle, from the lowest hitting channel index. Other same-cycle console hits are dropped and set `con_overflow_o`.
- A push into a full FIFO is dropped and sets `con_overflow_o`. The exception is a push in the same cycle as a pop: it is accepted.
- The console FIFO keeps accepting writes and draining in both RUN and DONE.
- Pop: the FIFO pops when `con_valid_o` and `con_ready_i` are both high. `con_data_o` is stable while valid and not ready.

## Timing
- Reset values:
  - `done_o`, `pass_o`, `timeout_o`: 0
  - `fail_code_o`: 0
  - `fail_ch_o`: 0
  - `cycle_o`: 0
  - `con_valid_o`: 0
  - `con_data_o`: 0
  - `con_overflow_o`: 0
  - FIFO empty; `reported` cleared.
- `cycle_o` increments every cycle after reset deassertion. It equals n in the n-th cycle after reset.
- Verdict latency: `done_o` and the qualifier outputs rise in the cycle after the deciding write or timeout cycle. They rise together and are registered.
- Console latency: a push at edge t gives `con_valid_o` = 1 after edge t when the FIFO was empty. There is no combinational path from the bus inputs to `con_*`.
- FIFO pointers are `log2(CON_DEPTH)+1` bits wide and wrap modulo `2*CON_DEPTH`. Full means MSBs differ and the rest are equal; empty means the pointers are equal.
- `rst_i` mid-test clears everything, including the FIFO contents and the overflow flag.

## Configuration
- `SIM_TEST_MONITOR_CONSOLE_EN` defined: the console FIFO and the `con_*` logic are built as described.
- Macro undefined: no FIFO storage is built. CONSOLE writes are ignored. `con_valid_o`, `con_data_o` and `con_overflow_o` are tied to 0, and `con_ready_i` is unused.
- STATUS, timeout and cycle logic are identical in both builds.

## Test plan
- N_CH=1: a STATUS write of 32'h777 at cycle 50 gives `done_o`=1 and `pass_o`=1 at cycle 51, with `cycle_o` frozen at 51.
- N_CH=2: channel 1 writes 32'h777. Then channels 0 and 1 both write 32'hDEAD in the same cycle. Result: `fail_ch_o`=0, `fail_code_o`=32'hDEAD, `pass_o`=0.
- TIMEOUT_CYCLES=100 with no writes: `done_o`=1 and `timeout_o`=1 with `cycle_o`=100. A later 32'h777 write changes nothing.
- Console with CON_DEPTH=4 and `con_ready_i`=0: write 'A','B','C','D','E'. Result: `con_overflow_o`=1. After raising ready, the drain order is A,B,C,D.
- Console full with a same-cycle push 'X' and pop: 'X' is accepted and `con_overflow_o` stays 0.
- Assert `rst_i` for one cycle after a FAIL: all outputs return to their reset values and a subsequent 32'h777 write passes.
